// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: takes timer interrupts, ECALL and MRET at a commit boundary,
// writes mepc/mcause/mstatus one at a time through a CSR port shared with the CPU, then redirects the PC.
module trap_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic [63:0] inst_pc_i,
  input  logic        ecall_i,
  input  logic        mret_i,
  input  logic        global_int_en_i,
  input  logic        mtime_int_en_i,
  input  logic        mtime_int_pend_i,
  input  logic [63:0] csr_mtvec_i,
  input  logic [63:0] csr_mepc_i,
  input  logic [63:0] csr_mstatus_i,
  input  logic        cpu_csr_wen_i,
  output logic        mepc_wen_o,
  output logic [63:0] mepc_wdata_o,
  output logic        mcause_wen_o,
  output logic [63:0] mcause_wdata_o,
  output logic        mstatus_wen_o,
  output logic [63:0] mstatus_wdata_o,
  output logic        hold_o,
  output logic        redirect_o,
  output logic [63:0] redirect_pc_o
);

  localparam logic [63:0] INT_CAUSE   = 64'h8000_0000_0000_0007;
  localparam logic [63:0] ECALL_CAUSE = 64'd11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_EPC    = 3'd1,
    W_CAUSE  = 3'd2,
    W_STATUS = 3'd3,
    MRET_ST  = 3'd4,
    JUMP     = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [63:0] pc_q, cause_q;
  logic        is_mret_q;
  logic        int_take, ecall_take, mret_take;

  assign int_take   = inst_valid_i & global_int_en_i & mtime_int_en_i & mtime_int_pend_i;
  assign ecall_take = inst_valid_i & ecall_i;
  assign mret_take  = inst_valid_i & mret_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc_q      <= '0;
      cause_q   <= '0;
      is_mret_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (int_take | ecall_take) begin
          pc_q      <= inst_pc_i;
          cause_q   <= int_take ? INT_CAUSE : ECALL_CAUSE;
          is_mret_q <= 1'b0;
        end else if (mret_take) begin
          is_mret_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    mepc_wen_o      = 1'b0;
    mepc_wdata_o    = '0;
    mcause_wen_o    = 1'b0;
    mcause_wdata_o  = '0;
    mstatus_wen_o   = 1'b0;
    mstatus_wdata_o = '0;
    hold_o          = 1'b0;
    redirect_o      = 1'b0;
    redirect_pc_o   = '0;
    case (state)
      IDLE: begin
        if (int_take | ecall_take) begin
          hold_o    = 1'b1;
          state_nxt = W_EPC;
        end else if (mret_take) begin
          hold_o    = 1'b1;
          state_nxt = MRET_ST;
        end
      end
      // Write states yield the CSR port to the CPU and retry on the next free cycle.
      W_EPC: begin
        hold_o = 1'b1;
        if (!cpu_csr_wen_i) begin
          mepc_wen_o   = 1'b1;
          mepc_wdata_o = pc_q;
          state_nxt    = W_CAUSE;
        end
      end
      W_CAUSE: begin
        hold_o = 1'b1;
        if (!cpu_csr_wen_i) begin
          mcause_wen_o   = 1'b1;
          mcause_wdata_o = cause_q;
          state_nxt      = W_STATUS;
        end
      end
      W_STATUS: begin
        hold_o = 1'b1;
        if (!cpu_csr_wen_i) begin
          mstatus_wen_o       = 1'b1;
          mstatus_wdata_o     = csr_mstatus_i;
          mstatus_wdata_o[7]  = csr_mstatus_i[3];
          mstatus_wdata_o[3]  = 1'b0;
          mstatus_wdata_o[12:11] = 2'b11;
          state_nxt           = JUMP;
        end
      end
      MRET_ST: begin
        hold_o = 1'b1;
        if (!cpu_csr_wen_i) begin
          mstatus_wen_o       = 1'b1;
          mstatus_wdata_o     = csr_mstatus_i;
          mstatus_wdata_o[3]  = csr_mstatus_i[7];
          mstatus_wdata_o[7]  = 1'b1;
          mstatus_wdata_o[12:11] = 2'b11;
          state_nxt           = JUMP;
        end
      end
      JUMP: begin
        hold_o        = 1'b1;
        redirect_o    = 1'b1;
        redirect_pc_o = is_mret_q ? csr_mepc_i : {csr_mtvec_i[63:2], 2'b00};
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Outputs must drop in the same cycle reset rises, not only after the state clears.
    if (rst) begin
      mepc_wen_o      = 1'b0;
      mepc_wdata_o    = '0;
      mcause_wen_o    = 1'b0;
      mcause_wdata_o  = '0;
      mstatus_wen_o   = 1'b0;
      mstatus_wdata_o = '0;
      hold_o          = 1'b0;
      redirect_o      = 1'b0;
      redirect_pc_o   = '0;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios plus random traffic, all checked against a
// transaction-level model (queue of pending CSR writes followed by one redirect).
module tb_trap_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid_i, ecall_i, mret_i;
  logic [63:0] inst_pc_i;
  logic        global_int_en_i, mtime_int_en_i, mtime_int_pend_i;
  logic [63:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic        cpu_csr_wen_i;
  logic        mepc_wen_o, mcause_wen_o, mstatus_wen_o, hold_o, redirect_o;
  logic [63:0] mepc_wdata_o, mcause_wdata_o, mstatus_wdata_o, redirect_pc_o;

  trap_ctrl dut (
    .clk(clk), .rst(rst), .inst_valid_i(inst_valid_i), .inst_pc_i(inst_pc_i),
    .ecall_i(ecall_i), .mret_i(mret_i), .global_int_en_i(global_int_en_i),
    .mtime_int_en_i(mtime_int_en_i), .mtime_int_pend_i(mtime_int_pend_i),
    .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
    .cpu_csr_wen_i(cpu_csr_wen_i),
    .mepc_wen_o(mepc_wen_o), .mepc_wdata_o(mepc_wdata_o),
    .mcause_wen_o(mcause_wen_o), .mcause_wdata_o(mcause_wdata_o),
    .mstatus_wen_o(mstatus_wen_o), .mstatus_wdata_o(mstatus_wdata_o),
    .hold_o(hold_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int cyc = 0, acc_cyc = 0, redir_cyc = 0;
  int n_mepc = 0, n_mcause = 0, n_mst = 0, n_redir = 0;
  logic [63:0] last_mepc, last_mcause, last_mst, last_rpc;

  // Model: pending writes (kind 0=mepc 1=mcause 2=mstatus-trap 3=mstatus-mret), then redirect.
  int          wk[$];
  logic [63:0] wd[$];
  bit          m_busy = 0, m_mret = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] trap_mst(input logic [63:0] m);
    return (m & ~64'h1888) | 64'h1800 | (m[3] ? 64'h80 : 64'h0);
  endfunction

  function automatic logic [63:0] mret_mst(input logic [63:0] m);
    return (m & ~64'h1808) | 64'h1880 | (m[7] ? 64'h8 : 64'h0);
  endfunction

  task automatic check_cycle();
    logic        e_hold, e_mepc, e_mcause, e_mst, e_redir, it, ec, mr, acc, pop, done;
    logic [63:0] d_mepc, d_mcause, d_mst, e_rpc;
    e_hold = 0; e_mepc = 0; e_mcause = 0; e_mst = 0; e_redir = 0;
    d_mepc = 0; d_mcause = 0; d_mst = 0; e_rpc = 0;
    acc = 0; pop = 0; done = 0;
    cyc++;
    if (rst) begin
      m_busy = 0; m_mret = 0; wk.delete(); wd.delete();
    end else if (!m_busy) begin
      it = inst_valid_i & global_int_en_i & mtime_int_en_i & mtime_int_pend_i;
      ec = inst_valid_i & ecall_i;
      mr = inst_valid_i & mret_i;
      if (it | ec) begin
        acc = 1; m_mret = 0;
        wk.push_back(0); wd.push_back(inst_pc_i);
        wk.push_back(1); wd.push_back(it ? 64'h8000_0000_0000_0007 : 64'd11);
        wk.push_back(2); wd.push_back(64'd0);
      end else if (mr) begin
        acc = 1; m_mret = 1;
        wk.push_back(3); wd.push_back(64'd0);
      end
      e_hold = acc;
    end else if (wk.size() != 0) begin
      e_hold = 1;
      if (!cpu_csr_wen_i) begin
        pop = 1;
        case (wk[0])
          0: begin e_mepc = 1; d_mepc = wd[0]; end
          1: begin e_mcause = 1; d_mcause = wd[0]; end
          2: begin e_mst = 1; d_mst = trap_mst(csr_mstatus_i); end
          default: begin e_mst = 1; d_mst = mret_mst(csr_mstatus_i); end
        endcase
      end
    end else begin
      e_hold = 1; e_redir = 1; done = 1;
      e_rpc = m_mret ? csr_mepc_i : (csr_mtvec_i & ~64'h3);
    end
    chk("hold", 64'(hold_o), 64'(e_hold));
    chk("mepc_wen", 64'(mepc_wen_o), 64'(e_mepc));
    chk("mepc_wdata", mepc_wdata_o, d_mepc);
    chk("mcause_wen", 64'(mcause_wen_o), 64'(e_mcause));
    chk("mcause_wdata", mcause_wdata_o, d_mcause);
    chk("mstatus_wen", 64'(mstatus_wen_o), 64'(e_mst));
    chk("mstatus_wdata", mstatus_wdata_o, d_mst);
    chk("redirect", 64'(redirect_o), 64'(e_redir));
    chk("redirect_pc", redirect_pc_o, e_rpc);
    if (mepc_wen_o) begin n_mepc++; last_mepc = mepc_wdata_o; end
    if (mcause_wen_o) begin n_mcause++; last_mcause = mcause_wdata_o; end
    if (mstatus_wen_o) begin n_mst++; last_mst = mstatus_wdata_o; end
    if (redirect_o) begin n_redir++; redir_cyc = cyc; last_rpc = redirect_pc_o; end
    if (acc) begin m_busy = 1; acc_cyc = cyc; end
    if (pop) begin void'(wk.pop_front()); void'(wd.pop_front()); end
    if (done) m_busy = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    inst_valid_i = 0; ecall_i = 0; mret_i = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && m_busy; i++) tick();
    chk("idle_timeout", 64'(m_busy), 64'd0);
  endtask

  task automatic run_int(input logic [63:0] pc);
    global_int_en_i = 1; mtime_int_en_i = 1; mtime_int_pend_i = 1;
    inst_valid_i = 1; inst_pc_i = pc;
    tick();
    clear_events();
  endtask

  int m0, c0, s0, r0;

  initial begin
    rst = 1; cpu_csr_wen_i = 0;
    inst_valid_i = 1; ecall_i = 1; mret_i = 0; inst_pc_i = 64'h8000_0040;
    global_int_en_i = 0; mtime_int_en_i = 0; mtime_int_pend_i = 0;
    csr_mtvec_i = 64'h8000_0003; csr_mepc_i = 64'h0; csr_mstatus_i = 64'h8;
    #1;
    tick(); tick();
    chk("rst_hold", 64'(hold_o), 64'd0);
    // Event already present when reset drops is taken at the first edge.
    rst = 0;
    tick();
    clear_events();
    wait_idle();
    chk("first_ecall_lat", 64'(redir_cyc - acc_cyc), 64'd4);
    chk("first_ecall_mepc", last_mepc, 64'h8000_0040);

    // Timer interrupt
    csr_mtvec_i = 64'h8000_0003; csr_mstatus_i = 64'h8;
    run_int(64'h8000_0100);
    global_int_en_i = 0;
    wait_idle();
    chk("int_mepc", last_mepc, 64'h8000_0100);
    chk("int_mcause", last_mcause, 64'h8000_0000_0000_0007);
    chk("int_mstatus", last_mst, 64'h1880);
    chk("int_rpc", last_rpc, 64'h8000_0000);
    chk("int_lat", 64'(redir_cyc - acc_cyc), 64'd4);

    // ECALL with the interrupt pending but globally disabled
    global_int_en_i = 0; mtime_int_en_i = 1; mtime_int_pend_i = 1;
    inst_valid_i = 1; ecall_i = 1; inst_pc_i = 64'h8000_0200;
    tick(); clear_events();
    wait_idle();
    chk("ecall_mcause", last_mcause, 64'd11);
    chk("ecall_mepc", last_mepc, 64'h8000_0200);
    chk("ecall_mie", 64'(last_mst[3]), 64'd0);

    // MRET
    csr_mstatus_i = 64'h1880; csr_mepc_i = 64'h8000_0104;
    inst_valid_i = 1; mret_i = 1;
    tick(); clear_events();
    wait_idle();
    chk("mret_mstatus", last_mst, 64'h1888);
    chk("mret_rpc", last_rpc, 64'h8000_0104);
    chk("mret_lat", 64'(redir_cyc - acc_cyc), 64'd2);

    // CPU owns the CSR port for two cycles during the mcause write
    csr_mstatus_i = 64'h8;
    m0 = n_mepc; c0 = n_mcause; s0 = n_mst;
    run_int(64'h8000_0300);
    tick();
    cpu_csr_wen_i = 1; tick(); tick(); cpu_csr_wen_i = 0;
    wait_idle();
    chk("conf_lat", 64'(redir_cyc - acc_cyc), 64'd6);
    chk("conf_n_mepc", 64'(n_mepc - m0), 64'd1);
    chk("conf_n_mcause", 64'(n_mcause - c0), 64'd1);
    chk("conf_n_mstatus", 64'(n_mst - s0), 64'd1);

    // Interrupt and ECALL together: interrupt wins
    global_int_en_i = 1; mtime_int_en_i = 1; mtime_int_pend_i = 1;
    inst_valid_i = 1; ecall_i = 1; inst_pc_i = 64'h8000_0400;
    tick(); clear_events();
    wait_idle();
    chk("both_mcause", last_mcause, 64'h8000_0000_0000_0007);

    // Reset landing in the mstatus-write cycle
    s0 = n_mst; r0 = n_redir;
    run_int(64'h8000_0500);
    tick(); tick();
    #1 rst = 1;
    #1;
    chk("rst_mid_mst_wen", 64'(mstatus_wen_o), 64'd0);
    chk("rst_mid_mst_wdata", mstatus_wdata_o, 64'd0);
    chk("rst_mid_hold", 64'(hold_o), 64'd0);
    chk("rst_mid_redirect", 64'(redirect_o), 64'd0);
    tick();
    rst = 0; global_int_en_i = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("rst_no_mst", 64'(n_mst - s0), 64'd0);
    chk("rst_no_redir", 64'(n_redir - r0), 64'd0);
    run_int(64'h8000_0600);
    global_int_en_i = 0;
    wait_idle();
    chk("post_rst_lat", 64'(redir_cyc - acc_cyc), 64'd4);
    chk("post_rst_mepc", last_mepc, 64'h8000_0600);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      inst_valid_i     = ($urandom_range(0, 1) == 1);
      ecall_i          = ($urandom_range(0, 3) == 0);
      mret_i           = ($urandom_range(0, 3) == 0);
      global_int_en_i  = ($urandom_range(0, 1) == 1);
      mtime_int_en_i   = ($urandom_range(0, 1) == 1);
      mtime_int_pend_i = ($urandom_range(0, 2) == 0);
      cpu_csr_wen_i    = ($urandom_range(0, 3) == 0);
      inst_pc_i        = {$urandom(), $urandom()};
      csr_mtvec_i      = {$urandom(), $urandom()};
      csr_mepc_i       = {$urandom(), $urandom()};
      csr_mstatus_i    = {$urandom(), $urandom()};
      tick();
    end
    clear_events(); cpu_csr_wen_i = 0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 SHALL provide these ports:
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- inst_valid_i  in  1  instruction at inst_pc_i is at commit boundary
- inst_pc_i  in  64  PC of that instruction
- ecall_i  in  1  instruction is ECALL
- mret_i  in  1  instruction is MRET
- global_int_en_i  in  1  mstatus.MIE
- mtime_int_en_i  in  1  mie.MTIE
- mtime_int_pend_i  in  1  mip.MTIP
- csr_mtvec_i, csr_mepc_i, csr_mstatus_i  in  64 each  current CSR values
- cpu_csr_wen_i  in  1  CPU CSR write this cycle; CPU owns the CSR write port
- mepc_wen_o / mepc_wdata_o  out  1/64  mepc write
- mcause_wen_o / mcause_wdata_o  out  1/64  mcause write
- mstatus_wen_o / mstatus_wdata_o  out  1/64  mstatus write
- hold_o  out  1  stall fetch/commit
- redirect_o / redirect_pc_o  out  1/64  one-cycle PC redirect

Function
REQ-003 States SHALL be IDLE, W_EPC, W_CAUSE, W_STATUS, MRET_ST, JUMP; IDLE is encoded as 0.
REQ-004 In IDLE, int_take = inst_valid_i & global_int_en_i & mtime_int_en_i & mtime_int_pend_i.
REQ-005 Event priority in IDLE SHALL be int_take > ecall > mret; events are qualified by inst_valid_i.
REQ-006 On int_take or ecall in IDLE: latch pc = inst_pc_i. Latch cause = 64'h8000_0000_0000_0007 (interrupt) or 64'd11 (ecall). Go to W_EPC.
REQ-007 On mret (no higher-priority event) in IDLE: go to MRET_ST.
REQ-008 Transitions SHALL be W_EPC->W_CAUSE->W_STATUS->JUMP->IDLE and MRET_ST->JUMP->IDLE.
REQ-009 W_EPC SHALL assert mepc_wen_o with the latched pc.
REQ-010 W_CAUSE SHALL assert mcause_wen_o with the latched cause.
REQ-011 W_STATUS SHALL assert mstatus_wen_o with data = csr_mstatus_i, modified as: bit7 = csr_mstatus_i[3], bit3 = 0, [12:11] = 2'b11.
REQ-012 MRET_ST SHALL assert mstatus_wen_o with data = csr_mstatus_i, modified as: bit3 = csr_mstatus_i[7], bit7 = 1, [12:11] = 2'b11.
REQ-013 While cpu_csr_wen_i=1, W_EPC/W_CAUSE/W_STATUS/MRET_ST SHALL deassert all *_wen_o and hold state. Each write completes only in a cycle with cpu_csr_wen_i=0, so no write is lost.
REQ-014 At most one *_wen_o SHALL be high per cycle; all *_wen_o SHALL be 0 in IDLE and JUMP.
REQ-015 JUMP SHALL pulse redirect_o=1 for exactly one cycle.
REQ-016 In JUMP, redirect_pc_o SHALL be {csr_mtvec_i[63:2],2'b00} for a trap, and csr_mepc_i for mret. A latched is_mret flag selects between them.
REQ-017 redirect_pc_o SHALL be 0 when redirect_o=0.
REQ-018 hold_o SHALL be (state!=IDLE) | (IDLE & accepted event), combinationally.
REQ-019 Latency SHALL be: trap accept to redirect = 4 cycles with no CPU conflicts; mret = 2 cycles. Each conflict cycle adds one cycle.
REQ-020 Events presented while not in IDLE SHALL be ignored; the source must hold them, which hold_o guarantees.
REQ-021 All *_wdata_o SHALL be 0 when the matching wen is 0.

Reset
REQ-022 rst=1 SHALL immediately (asynchronously) force state=IDLE, latched pc/cause/is_mret=0, and all outputs 0, including mid-sequence.
REQ-023 After rst deasserts, the first event SHALL be accepted on the first rising edge with it present.

Verification
REQ-024 Interrupt: MIE=MTIE=MTIP=1, inst_pc_i=0x8000_0100, mtvec=0x8000_0003, mstatus=0x8 -> writes, in order:
- mepc=0x8000_0100
- mcause=0x8000_0000_0000_0007
- mstatus=0x1880
- then redirect_pc_o=0x8000_0000 four cycles after accept.
REQ-025 ECALL with pending but disabled interrupt (MIE=0), pc=0x8000_0200 -> mcause=11, mepc=0x8000_0200, mstatus MIE=0.
REQ-026 MRET with mstatus=0x1880, mepc=0x8000_0104 -> mstatus=0x1888, redirect_pc_o=0x8000_0104 two cycles after accept.
REQ-027 cpu_csr_wen_i high for 2 cycles during W_CAUSE -> mcause write delayed 2 cycles, redirect at cycle 6, no duplicate or missing writes.
REQ-028 Simultaneous interrupt+ecall -> mcause=0x8000_0000_0000_0007.
REQ-029 rst asserted in W_STATUS -> outputs 0 in the same cycle, no mstatus write, no redirect; the next event runs a full clean sequence.
